// File: rtl/calc_operand_entry.sv
// Keypad front end for the 4-digit BCD calculator: builds two BCD operands and an op select,
// strobes the arithmetic unit on '='. Optional build macro CHAIN_RESULT_EN chains the result into operand A.
module calc_operand_entry #(
    parameter int MAX_DIGITS = 4
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [3:0] result_ones,
    input  logic [3:0] result_tens,
    input  logic [3:0] result_hundreds,
    input  logic [3:0] result_thousands,
    output logic [3:0] num1_ones,
    output logic [3:0] num1_tens,
    output logic [3:0] num1_hundreds,
    output logic [3:0] num1_thousands,
    output logic [3:0] num2_ones,
    output logic [3:0] num2_tens,
    output logic [3:0] num2_hundreds,
    output logic [3:0] num2_thousands,
    output logic       op_selected,
    output logic       calc_strobe,
    output logic [1:0] disp_sel,
    output logic       entry_err
);

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_EQ  = 4'd12;
    localparam logic [3:0] KEY_BS  = 4'd13;
    localparam logic [3:0] KEY_CE  = 4'd14;

    // Encoding doubles as the disp_sel value for each state.
    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        RESULT  = 2'd2
    } state_t;

    // Operand digits: index 0 = ones .. index 3 = thousands.
    typedef struct packed {
        logic [3:0][3:0] d;
        logic [2:0]      cnt;
        logic            err;
    } entry_t;

    state_t          state_q, state_d;
    logic [3:0][3:0] num1_q, num1_d, num2_q, num2_d;
    logic [2:0]      cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic            op_q, op_d, strobe_q, strobe_d, err_q, err_d;
    entry_t          edit_a, edit_b;

    // Digit / backspace / CE editing of one operand; other keys pass it through unchanged.
    function automatic entry_t edit(input logic [3:0][3:0] d, input logic [2:0] cnt,
                                    input logic [3:0] key);
        entry_t r;
        r.d   = d;
        r.cnt = cnt;
        r.err = 1'b0;
        if (key <= 4'd9) begin
            if (cnt == 3'd0 && key == 4'd0) begin
                r.cnt = 3'd0;
            end else if (cnt >= 3'(MAX_DIGITS)) begin
                r.err = 1'b1;
            end else begin
                r.d   = {d[2:0], key};
                r.cnt = cnt + 3'd1;
            end
        end else if (key == KEY_BS) begin
            if (cnt != 3'd0) begin
                r.d   = {4'd0, d[3:1]};
                r.cnt = cnt - 3'd1;
            end
        end else if (key == KEY_CE) begin
            r.d   = '0;
            r.cnt = 3'd0;
        end
        return r;
    endfunction

    assign edit_a = edit(num1_q, cnt_a_q, key_code);
    assign edit_b = edit(num2_q, cnt_b_q, key_code);

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can infer a latch.
        state_d  = state_q;
        num1_d   = num1_q;
        num2_d   = num2_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        op_d     = op_q;
        strobe_d = 1'b0;
        err_d    = 1'b0;
        if (key_valid) begin
            unique case (state_q)
                ENTER_A: begin
                    if (key_code == KEY_ADD || key_code == KEY_SUB) begin
                        op_d    = (key_code == KEY_SUB);
                        num2_d  = '0;
                        cnt_b_d = 3'd0;
                        state_d = ENTER_B;
                    end else if (key_code == KEY_EQ) begin
                        err_d = 1'b1;
                    end else begin
                        num1_d  = edit_a.d;
                        cnt_a_d = edit_a.cnt;
                        err_d   = edit_a.err;
                    end
                end
                ENTER_B: begin
                    if (key_code == KEY_ADD || key_code == KEY_SUB) begin
                        op_d = (key_code == KEY_SUB);
                    end else if (key_code == KEY_EQ) begin
                        strobe_d = 1'b1;
                        state_d  = RESULT;
                    end else begin
                        num2_d  = edit_b.d;
                        cnt_b_d = edit_b.cnt;
                        err_d   = edit_b.err;
                    end
                end
                RESULT: begin
                    if (key_code <= 4'd9) begin
                        num1_d  = {12'd0, key_code};
                        cnt_a_d = (key_code != 4'd0) ? 3'd1 : 3'd0;
                        num2_d  = '0;
                        cnt_b_d = 3'd0;
                        state_d = ENTER_A;
                    end else if (key_code == KEY_ADD || key_code == KEY_SUB) begin
`ifdef CHAIN_RESULT_EN
                        num1_d = {result_thousands, result_hundreds, result_tens, result_ones};
                        if (result_thousands != 4'd0)     cnt_a_d = 3'd4;
                        else if (result_hundreds != 4'd0) cnt_a_d = 3'd3;
                        else if (result_tens != 4'd0)     cnt_a_d = 3'd2;
                        else if (result_ones != 4'd0)     cnt_a_d = 3'd1;
                        else                              cnt_a_d = 3'd0;
`endif
                        op_d    = (key_code == KEY_SUB);
                        num2_d  = '0;
                        cnt_b_d = 3'd0;
                        state_d = ENTER_B;
                    end else if (key_code == KEY_EQ) begin
                        strobe_d = 1'b1;
                    end else if (key_code == KEY_CE) begin
                        num1_d  = '0;
                        num2_d  = '0;
                        cnt_a_d = 3'd0;
                        cnt_b_d = 3'd0;
                        op_d    = 1'b0;
                        state_d = ENTER_A;
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= ENTER_A;
            num1_q   <= '0;
            num2_q   <= '0;
            cnt_a_q  <= 3'd0;
            cnt_b_q  <= 3'd0;
            op_q     <= 1'b0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            num1_q   <= num1_d;
            num2_q   <= num2_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            op_q     <= op_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
        end
    end

    assign {num1_thousands, num1_hundreds, num1_tens, num1_ones} = num1_q;
    assign {num2_thousands, num2_hundreds, num2_tens, num2_ones} = num2_q;
    assign op_selected = op_q;
    assign calc_strobe = strobe_q;
    assign entry_err   = err_q;
    assign disp_sel    = state_q;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed self-checking bench for calc_operand_entry; expectations are hand-computed BCD values.
`timescale 1ns/100ps
module tb_calc_operand_entry;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] result_ones = 4'd0, result_tens = 4'd0, result_hundreds = 4'd0, result_thousands = 4'd0;
    logic [3:0] num1_ones, num1_tens, num1_hundreds, num1_thousands;
    logic [3:0] num2_ones, num2_tens, num2_hundreds, num2_thousands;
    logic       op_selected, calc_strobe, entry_err;
    logic [1:0] disp_sel;

    int pass_cnt = 0;
    int total_cnt = 0;

    calc_operand_entry #(.MAX_DIGITS(4)) dut (
        .clk(clk), .clear_n(clear_n), .key_valid(key_valid), .key_code(key_code),
        .result_ones(result_ones), .result_tens(result_tens),
        .result_hundreds(result_hundreds), .result_thousands(result_thousands),
        .num1_ones(num1_ones), .num1_tens(num1_tens),
        .num1_hundreds(num1_hundreds), .num1_thousands(num1_thousands),
        .num2_ones(num2_ones), .num2_tens(num2_tens),
        .num2_hundreds(num2_hundreds), .num2_thousands(num2_thousands),
        .op_selected(op_selected), .calc_strobe(calc_strobe),
        .disp_sel(disp_sel), .entry_err(entry_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] n1();
        return {num1_thousands, num1_hundreds, num1_tens, num1_ones};
    endfunction

    function automatic logic [15:0] n2();
        return {num2_thousands, num2_hundreds, num2_tens, num2_ones};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one key for a single cycle, then sample #1 after the capturing edge.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_num1", n1(), 16'h0000);
        check("rst_num2", n2(), 16'h0000);
        check("rst_op", 16'(op_selected), 16'd0);
        check("rst_strobe", 16'(calc_strobe), 16'd0);
        check("rst_err", 16'(entry_err), 16'd0);
        check("rst_disp", 16'(disp_sel), 16'd0);
        @(negedge clk);
        clear_n = 1'b1;

        // Four digits accepted, fifth rejected
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("a4_num1", n1(), 16'h1234);
        check("a4_err", 16'(entry_err), 16'd0);
        press(4'd5);
        check("a5_num1", n1(), 16'h1234);
        check("a5_err", 16'(entry_err), 16'd1);
        check("a5_disp", 16'(disp_sel), 16'd0);
        idle();
        check("a5_err_drop", 16'(entry_err), 16'd0);

        // Leading zeros do not consume digit slots
        press(4'd14);
        check("ce_num1", n1(), 16'h0000);
        press(4'd0); press(4'd0); press(4'd7);
        check("lz_num1", n1(), 16'h0007);
        press(4'd1); press(4'd2); press(4'd3);
        check("lz_full", n1(), 16'h7123);
        check("lz_full_err", 16'(entry_err), 16'd0);
        press(4'd4);
        check("lz_over_err", 16'(entry_err), 16'd1);
        check("lz_over_num1", n1(), 16'h7123);

        // Code 15 ignored silently
        press(4'd15);
        check("k15_num1", n1(), 16'h7123);
        check("k15_err", 16'(entry_err), 16'd0);

        // '=' in ENTER_A is an error
        press(4'd12);
        check("eqA_err", 16'(entry_err), 16'd1);
        check("eqA_strobe", 16'(calc_strobe), 16'd0);
        check("eqA_disp", 16'(disp_sel), 16'd0);

        // 5,6,backspace,'-',9,'='
        press(4'd14);
        press(4'd5); press(4'd6);
        check("bs_pre", n1(), 16'h0056);
        press(4'd13);
        check("bs_num1", n1(), 16'h0005);
        press(4'd11);
        check("sub_op", 16'(op_selected), 16'd1);
        check("sub_disp", 16'(disp_sel), 16'd1);
        check("sub_num2", n2(), 16'h0000);
        press(4'd9);
        check("b_num2", n2(), 16'h0009);
        check("b_num1", n1(), 16'h0005);
        press(4'd12);
        check("eq_strobe", 16'(calc_strobe), 16'd1);
        check("eq_err", 16'(entry_err), 16'd0);
        check("eq_disp", 16'(disp_sel), 16'd2);
        idle();
        check("eq_strobe_drop", 16'(calc_strobe), 16'd0);

        // Repeat '=' twice in RESULT
        press(4'd12);
        check("rep1_strobe", 16'(calc_strobe), 16'd1);
        idle();
        check("rep1_drop", 16'(calc_strobe), 16'd0);
        press(4'd12);
        check("rep2_strobe", 16'(calc_strobe), 16'd1);
        check("rep_num1", n1(), 16'h0005);
        check("rep_num2", n2(), 16'h0009);
        check("rep_op", 16'(op_selected), 16'd1);
        press(4'd13);
        check("resbs_num1", n1(), 16'h0005);
        check("resbs_err", 16'(entry_err), 16'd0);
        check("resbs_disp", 16'(disp_sel), 16'd2);

        // '+' from RESULT: chained result or held num1 depending on build
        result_thousands = 4'd0; result_hundreds = 4'd1; result_tens = 4'd2; result_ones = 4'd0;
        press(4'd10);
`ifdef CHAIN_RESULT_EN
        check("chain_num1", n1(), 16'h0120);
`else
        check("chain_num1", n1(), 16'h0005);
`endif
        check("chain_op", 16'(op_selected), 16'd0);
        check("chain_num2", n2(), 16'h0000);
        check("chain_disp", 16'(disp_sel), 16'd1);

        // ENTER_B op change, then async reset between edges
        press(4'd8);
        check("b2_num2", n2(), 16'h0008);
        press(4'd11);
        check("b2_op", 16'(op_selected), 16'd1);
        check("b2_disp", 16'(disp_sel), 16'd1);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd12;
        #1 clear_n = 1'b0;
        #1;
        check("arst_num1", n1(), 16'h0000);
        check("arst_num2", n2(), 16'h0000);
        check("arst_op", 16'(op_selected), 16'd0);
        check("arst_disp", 16'(disp_sel), 16'd0);
        clear_n = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("arst_no_strobe", 16'(calc_strobe), 16'd0);
        check("arst_eqA_err", 16'(entry_err), 16'd1);

        // Digit in RESULT restarts entry; zero digit leaves cnt_a at 0
        press(4'd2); press(4'd10); press(4'd3); press(4'd12);
        check("r2_disp", 16'(disp_sel), 16'd2);
        press(4'd0);
        check("rd0_num1", n1(), 16'h0000);
        check("rd0_num2", n2(), 16'h0000);
        check("rd0_disp", 16'(disp_sel), 16'd0);
        press(4'd7); press(4'd1); press(4'd2); press(4'd3);
        check("rd0_full", n1(), 16'h7123);
        check("rd0_full_err", 16'(entry_err), 16'd0);

        // CE in RESULT is a full return to reset state
        press(4'd11); press(4'd4); press(4'd12);
        press(4'd14);
        check("rce_num1", n1(), 16'h0000);
        check("rce_num2", n2(), 16'h0000);
        check("rce_op", 16'(op_selected), 16'd0);
        check("rce_disp", 16'(disp_sel), 16'd0);
        check("rce_strobe", 16'(calc_strobe), 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
